// File: rtl/sram_arbiter.sv
// Three-port arbiter in front of the single SRAM controller.
// Port 0 (video, read-only) has priority, bounded by a consecutive-grant limit
// while the draw engine (port 1, write-only) or host (port 2, read/write) waits.
// Ports 1 and 2 share the remaining slots round-robin.
// One transaction is in flight at a time: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> ACK.
module sram_arbiter #(
    parameter int AW             = 18,
    parameter int DW             = 16,
    parameter int VID_MAX_CONSEC = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic [AW-1:0] p0_addr,
    output logic          p0_ack,
    input  logic          p1_req,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_ack,
    input  logic          p2_req,
    input  logic          p2_we,
    input  logic [AW-1:0] p2_addr,
    input  logic [DW-1:0] p2_wdata,
    output logic          p2_ack,
    output logic [DW-1:0] rdata,
    output logic          sram_write,
    output logic          sram_read,
    output logic [AW-1:0] sram_address,
    output logic [DW-1:0] sram_data_write,
    input  logic [DW-1:0] sram_data_read,
    input  logic          sram_ready
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        ACK
    } state_t;

    localparam logic [3:0] CONSEC_MAX = 4'(VID_MAX_CONSEC);

    state_t     state;
    logic [1:0] grant;
    logic       op_read;
    logic [3:0] consec;
    logic       last_was_p2;

    logic       low_pending;
    logic       vid_blocked;
    logic       pick_valid;
    logic [1:0] pick;

    assign low_pending = p1_req | p2_req;
    assign vid_blocked = (consec == CONSEC_MAX) && low_pending;

    // Choose the next port: video first unless its streak limit is hit, then round-robin between draw and host.
    always_comb begin
        pick_valid = 1'b0;
        pick       = 2'd0;
        if (p0_req && !vid_blocked) begin
            pick_valid = 1'b1;
            pick       = 2'd0;
        end else if (p1_req && p2_req) begin
            pick_valid = 1'b1;
            pick       = last_was_p2 ? 2'd1 : 2'd2;
        end else if (p1_req) begin
            pick_valid = 1'b1;
            pick       = 2'd1;
        end else if (p2_req) begin
            pick_valid = 1'b1;
            pick       = 2'd2;
        end
    end

    // Transaction sequencer: latches the winner, pulses the strobe, tracks ready, and returns the ack and read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            grant           <= 2'd0;
            op_read         <= 1'b0;
            consec          <= 4'd0;
            last_was_p2     <= 1'b1;
            p0_ack          <= 1'b0;
            p1_ack          <= 1'b0;
            p2_ack          <= 1'b0;
            rdata           <= '0;
            sram_write      <= 1'b0;
            sram_read       <= 1'b0;
            sram_address    <= '0;
            sram_data_write <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            p2_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (sram_ready && pick_valid) begin
                        grant <= pick;
                        state <= ISSUE;
                        case (pick)
                            2'd0: begin
                                op_read         <= 1'b1;
                                sram_read       <= 1'b1;
                                sram_address    <= p0_addr;
                                sram_data_write <= '0;
                                if (low_pending)
                                    consec <= (consec == CONSEC_MAX) ? CONSEC_MAX : consec + 4'd1;
                                else
                                    consec <= 4'd0;
                            end
                            2'd1: begin
                                op_read         <= 1'b0;
                                sram_write      <= 1'b1;
                                sram_address    <= p1_addr;
                                sram_data_write <= p1_wdata;
                                consec          <= 4'd0;
                                last_was_p2     <= 1'b0;
                            end
                            default: begin
                                op_read         <= ~p2_we;
                                sram_read       <= ~p2_we;
                                sram_write      <= p2_we;
                                sram_address    <= p2_addr;
                                sram_data_write <= p2_wdata;
                                consec          <= 4'd0;
                                last_was_p2     <= 1'b1;
                            end
                        endcase
                    end
                end
                ISSUE: begin
                    sram_write <= 1'b0;
                    sram_read  <= 1'b0;
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (!sram_ready)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (sram_ready) begin
                        if (op_read)
                            rdata <= sram_data_read;
                        p0_ack <= (grant == 2'd0);
                        p1_ack <= (grant == 2'd1);
                        p2_ack <= (grant == 2'd2);
                        state  <= ACK;
                    end
                end
                ACK: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single SRAM controller between three requesters, one transaction at a time:
  - port 0: VGA pixel fetch, read-only, high priority.
  - port 1: draw engine, write-only.
  - port 2: host/debug, read or write.
- Sits between the requesters and the SRAM controller's write/read/address/data_write/data_read/ready interface.
- Sequences the one-cycle command strobe, waits for the controller to finish, and returns a one-cycle ack with read data.

Parameters:
- AW, 18, address width.
- DW, 16, data width.
- VID_MAX_CONSEC, 4, max consecutive port-0 grants while port 1 or 2 is pending; range 1..15.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- p0_req  in  1  video read request; held until ack.
- p0_addr  in  AW  video read address.
- p0_ack  out  1  one-cycle completion pulse.
- p1_req  in  1  draw write request; held until ack.
- p1_addr  in  AW  draw write address.
- p1_wdata  in  DW  draw write data.
- p1_ack  out  1  one-cycle completion pulse.
- p2_req  in  1  host request; held until ack.
- p2_we  in  1  host op: 1 = write, 0 = read.
- p2_addr  in  AW  host address.
- p2_wdata  in  DW  host write data.
- p2_ack  out  1  one-cycle completion pulse.
- rdata  out  DW  read data; valid in the p0_ack or p2_ack cycle and held until the next read completes.
- sram_write  out  1  write strobe to controller.
- sram_read  out  1  read strobe to controller.
- sram_address  out  AW  registered address to controller.
- sram_data_write  out  DW  registered write data to controller.
- sram_data_read  in  DW  controller read data.
- sram_ready  in  1  controller idle.

Behaviour:
- All outputs are registered.
- Reset values: every output 0, state IDLE, consec counter 0, round-robin pointer set to favour port 1.
- States:
  - IDLE: if sram_ready=1 and any req=1, arbitrate. Latch grant, op, address and wdata into the sram_* registers, then go to ISSUE. Otherwise stay.
  - ISSUE: exactly one cycle with sram_write or sram_read high, never both. Next state WAIT_BUSY.
  - WAIT_BUSY: stay until sram_ready=0, then WAIT_DONE.
  - WAIT_DONE: stay until sram_ready=1. On that edge, rdata <= sram_data_read if the op is a read, the granted ack is driven high, and state goes to ACK.
  - ACK: exactly one cycle with the granted pX_ack high. Next state IDLE.
- Strobes return to 0 on leaving ISSUE. sram_address and sram_data_write stay stable from ISSUE through ACK.
- Arbitration, evaluated in IDLE only:
  - Port 0 wins if p0_req=1, unless consec = VID_MAX_CONSEC and (p1_req or p2_req).
  - Otherwise ports 1 and 2 are round-robin: the port not served last wins when both request. The pointer updates only on a low-priority grant.
  - consec increments on a port-0 grant while p1_req or p2_req is high, saturating at VID_MAX_CONSEC.
  - consec clears on any port-1 or port-2 grant, and on a port-0 grant with no low-priority request pending.
- Handshake:
  - Requesters hold req, addr, wdata and we stable until they see ack.
  - Requesters drop req or present the next request on the cycle after ack.
  - Because IDLE follows ACK, a request still held in the cycle after ack is treated as a new transaction.
  - Inputs are sampled only in IDLE. Changes to a pending request's fields after grant are ignored.
- Latency: arbitration cycle s, strobe in s+1, ack in s+7 with the current controller timing (ready returns 5 cycles after the strobe). Sustained throughput is 1 transaction per 8 cycles. The design must not hard-code the wait count; it keys only on sram_ready.
- Boundary conditions:
  - Req dropped before grant: request is lost, no ack.
  - sram_ready=0 in IDLE (e.g. controller in reset): no arbitration, strobes stay 0.
  - Reset mid-transaction: immediate return to IDLE with outputs cleared. No ack is issued for the aborted request; the requester re-requests.
  - Data bit 13 is passed through unmodified; its reliability is a board-level issue.

Test Plan:
- Single port-1 write (addr 0x00123, data 0xA5A5) -> sram_write high exactly one cycle with sram_address=0x00123 and sram_data_write=0xA5A5; p1_ack 6 cycles after the strobe; no other ack.
- Port-2 read of 0x3FFFF with a controller model returning 0xBEEF -> sram_read pulse; p2_ack with rdata=0xBEEF; rdata held after ack.
- p0_req held continuously, p1_req held, VID_MAX_CONSEC=4 -> grant order 0,0,0,0,1,0,0,0,0,1...; each p0 ack spaced 8 cycles.
- p1_req and p2_req held together, p0 idle -> alternating grants 1,2,1,2; each ack pulse one cycle; no back-to-back double grant to the same port.
- Reset asserted in WAIT_DONE -> next cycle all strobes/acks/rdata 0, state IDLE; after release, the pending p2_req is served fresh with a single ack.
- sram_ready held low externally with p0_req=1 -> no strobe issued; strobe occurs the first IDLE cycle after ready rises.
